// File: rtl/gf_log_exp_pipe_if.sv
// Valid/ready operation and result channels of the GF(2^M) log/antilog unit.
// The master drives operations and result acceptance; the slave is the unit.
interface gf_log_exp_pipe_if #(
   parameter int unsigned GF_M  = 8,
   parameter int unsigned TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic             in_mode;
   logic [GF_M-1:0]  in_data;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [GF_M-1:0]  out_data;
   logic             out_zero;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_mode, in_data, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_zero, out_tag
   );

   modport slave (
      input  in_valid, in_mode, in_data, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_zero, out_tag
   );
endinterface

// File: rtl/gf_log_exp_pipe.sv
// Pipelined GF(2^M) discrete log / antilog lookup with valid/ready stall,
// sideband tag and a saturating count of log(0) requests.
module gf_log_exp_pipe #(
   parameter int unsigned     GF_M       = 8,
   parameter logic [GF_M:0]   PRIM_POLY  = 9'h15F,
   parameter int unsigned     PIPE_DEPTH = 2,
   parameter int unsigned     TAG_W      = 4,
   parameter int unsigned     CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   gf_log_exp_pipe_if.slave   bus,
   input  logic               zero_cnt_clr,
   output logic [CNT_W-1:0]   zero_cnt
);
   localparam int unsigned SZ = 1 << GF_M;
   localparam int unsigned N  = SZ - 1;

   typedef logic [SZ-1:0][GF_M-1:0] tab_t;

   function automatic logic [GF_M-1:0] mul_x(input logic [GF_M-1:0] p);
      logic [GF_M:0] s;
      s = {p, 1'b0};
      if (s[GF_M]) s = s ^ PRIM_POLY;
      return s[GF_M-1:0];
   endfunction

   function automatic tab_t build_exp();
      tab_t            t;
      logic [GF_M-1:0] p;
      t = '0;
      p = GF_M'(1);
      for (int unsigned i = 0; i < N; i++) begin
         t[GF_M'(i)] = p;
         p = mul_x(p);
      end
      // Exponent N (all ones) is congruent to 0, so it maps straight to 1.
      t[GF_M'(N)] = GF_M'(1);
      return t;
   endfunction

   function automatic tab_t build_log();
      tab_t            t;
      logic [GF_M-1:0] p;
      t = '0;
      p = GF_M'(1);
      for (int unsigned i = 0; i < N; i++) begin
         t[p] = GF_M'(i);
         p = mul_x(p);
      end
      return t;
   endfunction

   function automatic logic poly_ok();
      logic [SZ-1:0]   seen;
      logic [GF_M-1:0] p;
      logic            ok;
      seen = '0;
      ok   = 1'b1;
      p    = GF_M'(1);
      for (int unsigned i = 0; i < N; i++) begin
         if (seen[p]) ok = 1'b0;
         seen[p] = 1'b1;
         p = mul_x(p);
      end
      if (p != GF_M'(1)) ok = 1'b0;
      return ok;
   endfunction

   if (GF_M < 3 || GF_M > 10 || PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_param
      $error("gf_log_exp_pipe: GF_M or PIPE_DEPTH out of range");
   end

   if (!poly_ok()) begin : g_bad_poly
      $error("gf_log_exp_pipe: PRIM_POLY is not primitive for GF_M");
   end

   localparam tab_t EXP_TAB = build_exp();
   localparam tab_t LOG_TAB = build_log();

   logic                              adv;
   logic                              accept;
   logic                              lk_zero;
   logic [GF_M-1:0]                   lk_data;

   logic [PIPE_DEPTH-1:0]             vld_q,  vld_d;
   logic [PIPE_DEPTH-1:0]             zero_q, zero_d;
   logic [PIPE_DEPTH-1:0][GF_M-1:0]   data_q, data_d;
   logic [PIPE_DEPTH-1:0][TAG_W-1:0]  tag_q,  tag_d;
   logic [CNT_W-1:0]                  cnt_q,  cnt_d;

   logic [PIPE_DEPTH:0]               vld_ext;
   logic [PIPE_DEPTH:0]               zero_ext;
   logic [PIPE_DEPTH:0][GF_M-1:0]     data_ext;
   logic [PIPE_DEPTH:0][TAG_W-1:0]    tag_ext;

   always_comb begin
      adv    = !vld_q[PIPE_DEPTH-1] || bus.out_ready;
      accept = bus.in_valid && adv;

      if (bus.in_mode) begin
         lk_zero = 1'b0;
         lk_data = EXP_TAB[bus.in_data];
      end else begin
         lk_zero = (bus.in_data == '0);
         lk_data = lk_zero ? '0 : LOG_TAB[bus.in_data];
      end
   end

   // Stage 0 takes the lookup, every later stage takes its predecessor;
   // the extended vectors keep this uniform for PIPE_DEPTH = 1.
   always_comb begin
      vld_ext  = {vld_q,  accept};
      zero_ext = {zero_q, lk_zero};
      data_ext = {data_q, lk_data};
      tag_ext  = {tag_q,  bus.in_tag};

      vld_d  = vld_q;
      zero_d = zero_q;
      data_d = data_q;
      tag_d  = tag_q;
      if (adv) begin
         vld_d  = vld_ext[PIPE_DEPTH-1:0];
         zero_d = zero_ext[PIPE_DEPTH-1:0];
         data_d = data_ext[PIPE_DEPTH-1:0];
         tag_d  = tag_ext[PIPE_DEPTH-1:0];
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (zero_cnt_clr) begin
         cnt_d = '0;
      end else if (accept && !bus.in_mode && bus.in_data == '0 && cnt_q != '1) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         zero_q <= '0;
         data_q <= '0;
         tag_q  <= '0;
         cnt_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         zero_q <= zero_d;
         data_q <= data_d;
         tag_q  <= tag_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = vld_q[PIPE_DEPTH-1];
   assign bus.out_data  = data_q[PIPE_DEPTH-1];
   assign bus.out_zero  = zero_q[PIPE_DEPTH-1];
   assign bus.out_tag   = tag_q[PIPE_DEPTH-1];
   assign zero_cnt      = cnt_q;
endmodule

// File: tb/tb_gf_log_exp_pipe.sv
// Bench for gf_log_exp_pipe: GF(2^8) depth-2 instance driven through a scoreboard,
// plus a GF(2^4) depth-3 instance with a 2-bit counter for sweep and saturation.
`timescale 1ns/1ps
module tb_gf_log_exp_pipe;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr8, clr4;
   logic [15:0] zc8;
   logic [1:0]  zc4;

   always #5 clk = ~clk;

   gf_log_exp_pipe_if #(.GF_M(8), .TAG_W(4)) b8 ();
   gf_log_exp_pipe_if #(.GF_M(4), .TAG_W(4)) b4 ();

   gf_log_exp_pipe #(.GF_M(8), .PRIM_POLY(9'h15F), .PIPE_DEPTH(2), .TAG_W(4), .CNT_W(16)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(b8), .zero_cnt_clr(clr8), .zero_cnt(zc8)
   );

   gf_log_exp_pipe #(.GF_M(4), .PRIM_POLY(5'h13), .PIPE_DEPTH(3), .TAG_W(4), .CNT_W(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(b4), .zero_cnt_clr(clr4), .zero_cnt(zc4)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: field arithmetic by carry-less multiply and reduction.
   int exp8[255];
   int log8[256];
   int exp4[15];
   int log4[16];

   function automatic int gf_mul(input int a, input int b, input int m, input int poly);
      int r = 0;
      for (int i = 0; i < m; i++) if (((b >> i) & 1) != 0) r = r ^ (a << i);
      for (int i = 2 * m - 2; i >= m; i--) if (((r >> i) & 1) != 0) r = r ^ (poly << (i - m));
      return r;
   endfunction

   task automatic build_model();
      int acc = 1;
      for (int e = 0; e < 255; e++) begin
         exp8[e] = acc; log8[acc] = e; acc = gf_mul(acc, 2, 8, 'h15F);
      end
      acc = 1;
      for (int e = 0; e < 15; e++) begin
         exp4[e] = acc; log4[acc] = e; acc = gf_mul(acc, 2, 4, 'h13);
      end
      log8[0] = 0;
      log4[0] = 0;
   endtask

   function automatic void ref8(input bit mode, input int d, output int rd, output bit rz);
      if (mode) begin
         rd = exp8[d % 255]; rz = 1'b0;
      end else begin
         rz = (d == 0); rd = rz ? 0 : log8[d];
      end
   endfunction

   typedef struct {
      int data;
      bit zero;
      int tag;
      int acc;
   } exp_t;

   typedef struct {
      bit mode;
      int data;
      int tag;
      int expd;
      bit expz;
   } vec_t;

   exp_t sbq[$];
   bit   chk_lat = 1'b0;
   int   cnt_m   = 0;
   bit   prev_stall = 1'b0;
   int   prev_data, prev_tag;
   bit   prev_zero;

   // Result checker for the GF(2^8) instance, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         sbq.delete();
         cnt_m      = 0;
         prev_stall = 1'b0;
      end else begin
         chk("in_ready_rule", b8.in_ready, (!b8.out_valid || b8.out_ready) ? 1 : 0);
         chk("zero_cnt", zc8, cnt_m);
         if (prev_stall) begin
            chk("stall_out_data", b8.out_data, prev_data);
            chk("stall_out_zero", b8.out_zero, prev_zero);
            chk("stall_out_tag", b8.out_tag, prev_tag);
         end
         if (b8.out_valid && b8.out_ready) begin
            if (sbq.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("out_data", b8.out_data, e.data);
               chk("out_zero", b8.out_zero, e.zero);
               chk("out_tag", b8.out_tag, e.tag);
               if (chk_lat) chk("latency", cyc - e.acc, 2);
            end
         end
         if (clr8) cnt_m = 0;
         else if (b8.in_valid && b8.in_ready && !b8.in_mode && b8.in_data == 8'd0 && cnt_m != 65535)
            cnt_m++;
         prev_stall = b8.out_valid && !b8.out_ready;
         prev_data  = b8.out_data;
         prev_zero  = b8.out_zero;
         prev_tag   = b8.out_tag;
      end
   end

   task automatic send8(input bit mode, input int data, input int tag, input int expd, input bit expz);
      bit acc = 1'b0;
      int n   = 0;
      b8.in_valid = 1'b1;
      b8.in_mode  = mode;
      b8.in_data  = 8'(data);
      b8.in_tag   = 4'(tag);
      while (!acc && n < 200) begin
         @(negedge clk);
         if (b8.in_ready) begin
            exp_t e;
            e.data = expd; e.zero = expz; e.tag = tag; e.acc = cyc;
            sbq.push_back(e);
            acc = 1'b1;
         end
         @(posedge clk); #1;
         n++;
      end
      b8.in_valid = 1'b0;
      if (!acc) chk("send_accept_timeout", 0, 1);
   endtask

   task automatic send8_ref(input bit mode, input int data, input int tag);
      int rd;
      bit rz;
      ref8(mode, data, rd, rz);
      send8(mode, data, tag, rd, rz);
   endtask

   task automatic drain8();
      int n = 0;
      while (sbq.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_empty", sbq.size(), 0);
   endtask

   task automatic op4(input bit mode, input int data, input int tag,
                      output int rd, output int rz, output int rt, output int lat);
      b4.in_valid = 1'b1;
      b4.in_mode  = mode;
      b4.in_data  = 4'(data);
      b4.in_tag   = 4'(tag);
      @(posedge clk); #1;
      b4.in_valid = 1'b0;
      lat = 1;
      while (!b4.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = b4.out_data;
      rz = b4.out_zero;
      rt = b4.out_tag;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[11];
      bit   rnd_done;
      int   rd, rz, rt, lat;

      tbl[0]  = '{1'b0, 'h02, 8,  1,    1'b0};
      tbl[1]  = '{1'b0, 'h5F, 9,  8,    1'b0};
      tbl[2]  = '{1'b0, 'hAF, 10, 254,  1'b0};
      tbl[3]  = '{1'b0, 'h03, 11, 122,  1'b0};
      tbl[4]  = '{1'b1, 8,    12, 'h5F, 1'b0};
      tbl[5]  = '{1'b1, 122,  13, 'h03, 1'b0};
      tbl[6]  = '{1'b1, 254,  14, 'hAF, 1'b0};
      tbl[7]  = '{1'b1, 255,  15, 'h01, 1'b0};
      tbl[8]  = '{1'b0, 0,    1,  0,    1'b1};
      tbl[9]  = '{1'b0, 0,    2,  0,    1'b1};
      tbl[10] = '{1'b0, 0,    3,  0,    1'b1};

      build_model();
      rst_n = 1'b0;
      clr8 = 1'b0; clr4 = 1'b0;
      b8.in_valid = 1'b0; b8.in_mode = 1'b0; b8.in_data = '0; b8.in_tag = '0; b8.out_ready = 1'b1;
      b4.in_valid = 1'b0; b4.in_mode = 1'b0; b4.in_data = '0; b4.in_tag = '0; b4.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("reset_out_valid", b8.out_valid, 0);
      chk("reset_out_data", b8.out_data, 0);
      chk("reset_out_zero", b8.out_zero, 0);
      chk("reset_out_tag", b8.out_tag, 0);
      chk("reset_zero_cnt", zc8, 0);
      chk("reset_in_ready", b8.in_ready, 1);
      chk("reset_in_ready4", b4.in_ready, 1);
      @(posedge clk); #1;

      // Known vectors back to back, checking exact latency.
      chk_lat = 1'b1;
      for (int i = 0; i < 11; i++)
         send8(tbl[i].mode, tbl[i].data, tbl[i].tag, tbl[i].expd, tbl[i].expz);
      chk("zero_cnt_after3", zc8, 3);
      clr8 = 1'b1;
      send8(1'b0, 0, 4, 0, 1'b1);
      clr8 = 1'b0;
      chk("zero_cnt_clr_wins", zc8, 0);
      drain8();
      chk_lat = 1'b0;

      // Backpressure: six mixed ops with a four-cycle stall mid-stream.
      fork
         begin
            send8_ref(1'b0, 'h1D, 5);
            send8_ref(1'b1, 17,   6);
            send8_ref(1'b0, 0,    7);
            send8_ref(1'b1, 255,  8);
            send8_ref(1'b0, 'hFF, 9);
            send8_ref(1'b1, 0,    10);
         end
         begin
            repeat (2) @(posedge clk);
            #1 b8.out_ready = 1'b0;
            #1 chk("stall_in_ready_low", b8.in_ready, 0);
            repeat (4) @(posedge clk);
            #1 b8.out_ready = 1'b1;
         end
      join
      drain8();

      // Random mixed traffic with random downstream stalls.
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               int d;
               d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
               send8_ref(1'($urandom_range(0, 1)), d, int'($urandom_range(0, 15)));
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               b8.out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      b8.out_ready = 1'b1;
      drain8();

      // GF(2^8) round trip: LOG a then EXP of its log must give back a.
      for (int a = 1; a < 256; a++) begin
         send8(1'b0, a, a & 15, log8[a], 1'b0);
         send8(1'b1, log8[a], (a + 1) & 15, a, 1'b0);
      end
      drain8();

      // Reset with two operations in flight.
      send8(1'b0, 0, 5, 0, 1'b1);
      send8(1'b1, 3, 6, exp8[3], 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", b8.out_valid, 0);
      chk("rst_mid_zero_cnt", zc8, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("no_stale_after_reset", b8.out_valid, 0);
      end

      // GF(2^4), depth 3: exhaustive round trip and boundaries.
      for (int e = 1; e < 16; e++) begin
         int lg;
         op4(1'b0, e, e, rd, rz, rt, lat);
         chk("gf4_log", rd, log4[e]);
         chk("gf4_log_zero", rz, 0);
         chk("gf4_latency", lat, 3);
         lg = rd;
         op4(1'b1, lg, 15 - e, rd, rz, rt, lat);
         chk("gf4_roundtrip", rd, e);
         chk("gf4_tag", rt, 15 - e);
      end
      op4(1'b1, 15, 1, rd, rz, rt, lat);
      chk("gf4_exp15", rd, 1);
      op4(1'b1, 0, 2, rd, rz, rt, lat);
      chk("gf4_exp0", rd, 1);
      for (int i = 0; i < 4; i++) begin
         op4(1'b0, 0, i, rd, rz, rt, lat);
         chk("gf4_log0_data", rd, 0);
         chk("gf4_log0_zero", rz, 1);
      end
      chk("gf4_zero_cnt_sat", zc4, 3);
      clr4 = 1'b1;
      @(posedge clk); #1;
      clr4 = 1'b0;
      chk("gf4_zero_cnt_clr", zc4, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/gf_log_exp_pipe.md
Name: gf_log_exp_pipe

Overview:
- Parametrised, pipelined GF(2^M) discrete-log / antilog unit for the Unity ECC decoder datapath.
- Converts a field element to its exponent (LOG mode) or an exponent to its field element (EXP mode).
- Both tables are generated at elaboration from PRIM_POLY, and the unit is pipelined with valid/ready backpressure.
- Replaces fixed GF(2^8) log lookups in syndrome/locator stages and flags log(0) as undefined.

Parameters:
- GF_M, 8, field degree in bits; legal range 3..10.
- PRIM_POLY, 9'h15F, primitive polynomial of width GF_M+1 with the MSB set. The default is x^8+x^6+x^4+x^3+x^2+x+1.
- PIPE_DEPTH, 2, number of register stages from input to output; legal range 1..4.
- TAG_W, 4, width of the sideband tag carried alongside each operation.
- CNT_W, 16, width of the saturating log(0) event counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  unit accepts the operation this cycle.
- in_mode  in  1  0 = LOG (element -> exponent), 1 = EXP (exponent -> element).
- in_data  in  GF_M  element (LOG) or exponent (EXP).
- in_tag  in  TAG_W  opaque sideband, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  GF_M  exponent (LOG) or element (EXP).
- out_zero  out  1  LOG of element 0; out_data is forced to 0 when set.
- out_tag  out  TAG_W  tag of this result.
- zero_cnt  out  CNT_W  saturating count of accepted LOG-of-zero operations.
- zero_cnt_clr  in  1  synchronous clear of zero_cnt.

Behaviour:
- Tables are built at elaboration with N = 2^GF_M - 1.
  - Iterate p_0 = 1, p_{i+1} = p_i*x mod PRIM_POLY for i = 0..N-1.
  - exp_tab[i] = p_i; log_tab[p_i] = i.
  - Elaboration fails if p_N != 1, or if any p_i repeats for i < N (non-primitive polynomial).
- Arithmetic and boundaries:
  - LOG: out_data = log_tab[in_data], range 0..N-1. For in_data = 0: out_data = 0 and out_zero = 1.
  - EXP: out_data = exp_tab[in_data mod N]. Exponent N (all ones) maps to element 1. out_zero is always 0.
- Pipeline timing:
  - Lookup happens in stage 1; stages 2..PIPE_DEPTH are register-only.
  - Latency is exactly PIPE_DEPTH cycles from the accept edge to out_valid, with no stall.
- Handshake:
  - Global stall: adv = !out_valid || out_ready; in_ready = adv.
  - An operation is accepted when in_valid && in_ready.
  - The pipeline shifts only when adv = 1. Internal bubbles are not collapsed.
  - With out_ready held at 1, throughput is 1 op/cycle.
  - While out_valid && !out_ready: out_data, out_zero and out_tag stay stable, and in_ready = 0.
  - Inputs are ignored while in_ready = 0.
- zero_cnt:
  - Increments by 1 on each accepted LOG op with in_data = 0.
  - Saturates at 2^CNT_W - 1.
  - zero_cnt_clr wins over a simultaneous increment; the result is 0.
- Reset (async assert, synchronous-release usage assumed upstream):
  - All stage valid bits = 0, out_valid = 0, out_data = 0, out_zero = 0, out_tag = 0, zero_cnt = 0.
  - in_ready = 1 once rst_n is high.
  - Reset mid-operation discards all in-flight ops; no result emerges after release.
- Mixed modes:
  - LOG and EXP ops may interleave freely cycle by cycle.
  - Results return in order, each with its own tag.

Test Plan:
- Default params, PIPE_DEPTH = 2, out_ready = 1:
  - LOG 0x02, 0x5F, 0xAF, 0x03 -> out_data 1, 8, 254, 122.
  - Results appear exactly 2 cycles after each accept, one per cycle.
- EXP 8, 122, 254, 255 -> 0x5F, 0x03, 0xAF, 0x01; out_zero = 0 for all.
- LOG 0x00 three times with tags 1, 2, 3:
  - Each result has out_data = 0, out_zero = 1, tags returned in order.
  - zero_cnt = 3. zero_cnt_clr together with a fourth LOG 0 -> zero_cnt = 0.
- Backpressure: stream 6 mixed ops and hold out_ready = 0 for 4 cycles mid-stream.
  - Outputs and tags stay stable while stalled and in_ready = 0.
  - No op is lost or duplicated; order is preserved.
- Reset mid-stream: drive rst_n = 0 with 2 ops in flight.
  - out_valid drops immediately and zero_cnt = 0.
  - After release, no stale result appears.
- Exhaustive sweeps:
  - GF_M = 4, PRIM_POLY = 5'h13: LOG of every element 1..15 then EXP of the result returns the original element; EXP 15 -> 1.
  - GF_M = 8: the same round-trip sweep over all 255 elements.
